// File: rtl/cache_req_scheduler_pkg.sv
// rtl/cache_req_scheduler_pkg.sv - shared widths and scheduler state encoding
package cache_pkg;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 64;
   localparam int OFFSET_W = 3;
   localparam int INDEX_W  = 3;

   typedef logic [2:0] sched_state_t;

   localparam sched_state_t S_IDLE   = 3'd0;
   localparam sched_state_t S_LOOKUP = 3'd1;
   localparam sched_state_t S_CHECK  = 3'd2;
   localparam sched_state_t S_MEM_RD = 3'd3;
   localparam sched_state_t S_FILL   = 3'd4;
   localparam sched_state_t S_MEM_WR = 3'd5;
   localparam sched_state_t S_RESP   = 3'd6;

endpackage

// File: rtl/cache_req_scheduler_if.sv
// rtl/cache_req_scheduler_if.sv - requester, cache and memory signal bundle
interface cache_req_scheduler_if #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = cache_pkg::ADDR_W,
   parameter int DATA_W = cache_pkg::DATA_W
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_write;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        resp_valid;
   logic                    resp_hit;
   logic [7:0]              resp_data;
   logic [ADDR_W-1:0]       cache_addr;
   logic                    cache_read;
   logic                    cache_write;
   logic [DATA_W-1:0]       cache_wdata;
   logic                    cache_hit;
   logic [7:0]              cache_rdata;
   logic                    mem_req;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic                    mem_ack;
   logic [DATA_W-1:0]       mem_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  cache_hit, cache_rdata, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_hit, resp_data,
      output cache_addr, cache_read, cache_write, cache_wdata,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output cache_hit, cache_rdata, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_hit, resp_data,
      input  cache_addr, cache_read, cache_write, cache_wdata,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_req_scheduler_rr_arbiter.sv
// rtl/cache_req_scheduler_rr_arbiter.sv - round-robin grant with rotating priority pointer
module rr_arbiter #(
   parameter int N_REQ = 2,
   localparam int PTR_W = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             advance,
   output logic [N_REQ-1:0] grant
);
   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Scan from the pointer so an idle requester is simply skipped.
   always_comb begin
      int   idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      ptr_d = ptr_q;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr_q) + i) % N_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            if (advance) ptr_d = PTR_W'((idx + 1) % N_REQ);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/cache_req_scheduler.sv
// rtl/cache_req_scheduler.sv - one-at-a-time cache sequencer with read-allocate miss handling
module cache_req_scheduler import cache_pkg::*; #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = cache_pkg::ADDR_W,
   parameter int DATA_W = cache_pkg::DATA_W
) (
   input logic                   clk,
   input logic                   reset,
   cache_req_scheduler_if.slave  bus
);
   localparam int ID_W = $clog2(N_REQ);

   sched_state_t      state_q, state_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
   logic              resp_hit_q, resp_hit_d;
   logic [7:0]        resp_data_q, resp_data_d;
   logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
   logic              cache_read_q, cache_read_d;
   logic              cache_write_q, cache_write_d;
   logic [DATA_W-1:0] cache_wdata_q, cache_wdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   gnt_id;
   logic              accept;
   logic [7:0]        fill_byte;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (bus.req_valid),
      .advance (accept),
      .grant   (grant)
   );

   always_comb begin
      gnt_id = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant[i]) gnt_id = ID_W'(i);
   end

   assign bus.req_ready = (state_q == S_IDLE && reset) ? grant : '0;
   assign accept        = |(bus.req_valid & bus.req_ready);

   // The fetched line sits in cache_wdata_q during FILL; pick the requested byte.
   assign fill_byte = 8'(cache_wdata_q >> {addr_q[OFFSET_W-1:0], 3'b000});

   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      write_d       = write_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      resp_valid_d  = '0;
      resp_hit_d    = 1'b0;
      resp_data_d   = 8'h00;
      cache_addr_d  = cache_addr_q;
      cache_read_d  = 1'b0;
      cache_write_d = 1'b0;
      cache_wdata_d = cache_wdata_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      case (state_q)
         S_IDLE: if (accept) begin
            id_d          = gnt_id;
            write_d       = bus.req_write[gnt_id];
            addr_d        = bus.req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
            wdata_d       = bus.req_wdata[int'(gnt_id)*DATA_W +: DATA_W];
            cache_addr_d  = addr_d;
            cache_wdata_d = wdata_d;
            cache_read_d  = !write_d;
            cache_write_d = write_d;
            state_d       = S_LOOKUP;
         end
         S_LOOKUP: state_d = S_CHECK;
         S_CHECK: begin
            if (bus.cache_hit) begin
               resp_valid_d[id_q] = 1'b1;
               resp_hit_d         = 1'b1;
               resp_data_d        = write_q ? 8'h00 : bus.cache_rdata;
               state_d            = S_RESP;
            end else if (write_q) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = wdata_q;
               state_d     = S_MEM_WR;
            end else begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
               state_d    = S_MEM_RD;
            end
         end
         S_MEM_RD: if (bus.mem_ack) begin
            {mem_req_d, mem_we_d, mem_addr_d, mem_wdata_d} = '0;
            cache_read_d  = 1'b1;
            cache_addr_d  = addr_q;
            cache_wdata_d = bus.mem_rdata;
            state_d       = S_FILL;
         end
         S_FILL: begin
            resp_valid_d[id_q] = 1'b1;
            resp_data_d        = fill_byte;
            state_d            = S_RESP;
         end
         S_MEM_WR: if (bus.mem_ack) begin
            {mem_req_d, mem_we_d, mem_addr_d, mem_wdata_d} = '0;
            resp_valid_d[id_q] = 1'b1;
            state_d            = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         id_q          <= '0;
         write_q       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         resp_valid_q  <= '0;
         resp_hit_q    <= 1'b0;
         resp_data_q   <= 8'h00;
         cache_addr_q  <= '0;
         cache_read_q  <= 1'b0;
         cache_write_q <= 1'b0;
         cache_wdata_q <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         id_q          <= id_d;
         write_q       <= write_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         resp_valid_q  <= resp_valid_d;
         resp_hit_q    <= resp_hit_d;
         resp_data_q   <= resp_data_d;
         cache_addr_q  <= cache_addr_d;
         cache_read_q  <= cache_read_d;
         cache_write_q <= cache_write_d;
         cache_wdata_q <= cache_wdata_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_hit    = resp_hit_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.cache_addr  = cache_addr_q;
   assign bus.cache_read  = cache_read_q;
   assign bus.cache_write = cache_write_q;
   assign bus.cache_wdata = cache_wdata_q;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_cache_req_scheduler.sv
// tb/tb_cache_req_scheduler.sv - directed scoreboard bench with cache and memory responders
module tb_cache_req_scheduler;
   import cache_pkg::*;

   typedef struct {
      int         id;
      logic       hit;
      logic [7:0] data;
      int         due;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   cache_req_scheduler_if #(.N_REQ(2)) bus ();

   cache_req_scheduler #(.N_REQ(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // memory responder knobs and observations
   int          mem_k = 0;
   logic [63:0] mem_line = '0;
   logic        fill_pending = 1'b0;
   logic [31:0] obs_mem_addr;
   logic        obs_mem_we;
   logic [63:0] obs_mem_wdata;
   logic [63:0] obs_fill_wdata;
   int          n_cread = 0, n_cwrite = 0, n_memcyc = 0, n_resp = 0;
   logic [63:0] lines [int unsigned];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // cache: answers a strobe in the following cycle
   initial begin
      logic       nxt_hit;
      logic [7:0] nxt_data;
      int unsigned key;
      nxt_hit = 1'b0;
      nxt_data = 8'h00;
      bus.cache_hit = 1'b0;
      bus.cache_rdata = 8'h00;
      forever begin
         @(posedge clk); #1;
         bus.cache_hit = nxt_hit;
         bus.cache_rdata = nxt_data;
         nxt_hit = 1'b0;
         nxt_data = 8'h00;
         key = bus.cache_addr >> 3;
         if (bus.cache_read && fill_pending) begin
            fill_pending = 1'b0;
            lines[key] = bus.cache_wdata;
            obs_fill_wdata = bus.cache_wdata;
         end else if (bus.cache_read) begin
            if (lines.exists(key)) begin
               nxt_hit = 1'b1;
               nxt_data = 8'(lines[key] >> {bus.cache_addr[2:0], 3'b000});
            end
         end else if (bus.cache_write) begin
            if (lines.exists(key)) begin
               nxt_hit = 1'b1;
               lines[key] = bus.cache_wdata;
            end
         end
      end
   end

   // memory: acks k cycles after mem_req rises
   initial begin
      int cnt;
      cnt = 0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         bus.mem_ack = 1'b0;
         if (!bus.mem_req) cnt = 0;
         else if (cnt == mem_k) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = mem_line;
            obs_mem_addr = bus.mem_addr;
            obs_mem_we = bus.mem_we;
            obs_mem_wdata = bus.mem_wdata;
            if (!bus.mem_we) fill_pending = 1'b1;
            cnt = 0;
         end else cnt++;
      end
   end

   // output monitor: scoreboard pops, strobe rules, memory stability
   initial begin
      exp_t        e;
      logic        prev_strobe;
      logic        prev_mreq;
      logic [32:0] prev_mctl;
      logic [63:0] prev_mwd;
      prev_strobe = 1'b0;
      prev_mreq = 1'b0;
      prev_mctl = '0;
      prev_mwd = '0;
      forever begin
         @(negedge clk);
         if (bus.cache_read) n_cread++;
         if (bus.cache_write) n_cwrite++;
         if (bus.mem_req) n_memcyc++;
         if (bus.cache_read || bus.cache_write) begin
            check("strobe_exclusive", bus.cache_read & bus.cache_write, 0);
            check("strobe_one_cycle", prev_strobe, 0);
         end
         prev_strobe = bus.cache_read | bus.cache_write;
         if (bus.mem_req && prev_mreq) begin
            check("mem_ctl_stable", {bus.mem_we, bus.mem_addr}, prev_mctl);
            check("mem_wdata_stable", bus.mem_wdata, prev_mwd);
         end
         prev_mreq = bus.mem_req;
         prev_mctl = {bus.mem_we, bus.mem_addr};
         prev_mwd = bus.mem_wdata;
         if (|bus.resp_valid) begin
            n_resp++;
            if (sb.size() == 0) check("resp_unexpected", bus.resp_valid, 0);
            else begin
               e = sb.pop_front();
               check("resp_id", bus.resp_valid, 2'b01 << e.id);
               check("resp_hit", bus.resp_hit, e.hit);
               check("resp_data", bus.resp_data, e.data);
               check("resp_cycle", cyc, e.due);
            end
         end
      end
   end

   task automatic do_req(input int id, input logic wr, input logic [31:0] addr,
                         input logic [63:0] wd, input logic hit, input logic [7:0] data,
                         input int lat);
      logic acc;
      int   acc_cyc;
      acc = 1'b0;
      acc_cyc = 0;
      @(posedge clk); #1;
      bus.req_write[id] = wr;
      bus.req_addr[id*32 +: 32] = addr;
      bus.req_wdata[id*64 +: 64] = wd;
      bus.req_valid[id] = 1'b1;
      for (int t = 0; t < 40 && !acc; t++) begin
         @(negedge clk);
         if (bus.req_ready[id]) begin
            acc = 1'b1;
            acc_cyc = cyc;
         end
      end
      check("accept", acc, 1);
      sb.push_back('{id, hit, data, acc_cyc + lat});
      @(posedge clk); #1;
      bus.req_valid[id] = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 80; t++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("drain", sb.size(), 0);
      @(posedge clk);
   endtask

   initial begin
      int   c_rd, c_wr, c_mem, c_resp, last_acc, gid;
      logic acc;
      reset = 1'b0;
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      last_acc = 0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp", {bus.resp_valid, bus.resp_hit, bus.resp_data}, 0);
      check("rst_cache", {bus.cache_read, bus.cache_write, bus.cache_addr}, 0);
      check("rst_cache_wdata", bus.cache_wdata, 0);
      check("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr}, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      @(posedge clk); #2;
      reset = 1'b1;
      @(negedge clk);
      check("idle_ready", bus.req_ready, 0);
      check("idle_state", dut.state_q, S_IDLE);

      // read miss, k=3
      mem_k = 3; mem_line = 64'd1597;
      do_req(1, 1'b0, 32'd4104, 64'd0, 1'b0, 8'h3D, 8);
      drain();
      check("rdmiss_mem_addr", obs_mem_addr, 32'd4104);
      check("rdmiss_mem_we", obs_mem_we, 0);
      check("rdmiss_fill_wdata", obs_fill_wdata, 64'd1597);

      // install 448, then read hit
      mem_k = 1; mem_line = 64'd8246;
      do_req(0, 1'b0, 32'd448, 64'd0, 1'b0, 8'h36, 6);
      drain();
      c_mem = n_memcyc;
      do_req(0, 1'b0, 32'd448, 64'd0, 1'b1, 8'h36, 3);
      drain();
      check("rdhit_no_mem", n_memcyc - c_mem, 0);

      // install 72 with k=0
      mem_k = 0; mem_line = 64'h1122334455667788;
      do_req(1, 1'b0, 32'd72, 64'd0, 1'b0, 8'h88, 5);
      drain();

      // write hit
      c_rd = n_cread; c_wr = n_cwrite; c_mem = n_memcyc;
      do_req(0, 1'b1, 32'd72, 64'd3214, 1'b1, 8'h00, 3);
      drain();
      check("wrhit_one_write", n_cwrite - c_wr, 1);
      check("wrhit_no_read", n_cread - c_rd, 0);
      check("wrhit_no_mem", n_memcyc - c_mem, 0);

      // write miss, k=2
      mem_k = 2;
      c_rd = n_cread;
      do_req(1, 1'b1, 32'd3680, 64'd2000, 1'b0, 8'h00, 6);
      drain();
      check("wrmiss_no_read", n_cread - c_rd, 0);
      check("wrmiss_mem_we", obs_mem_we, 1);
      check("wrmiss_mem_wdata", obs_mem_wdata, 64'd2000);
      check("wrmiss_mem_addr", obs_mem_addr, 32'd3680);

      // fairness: both hold valid across four hits
      @(posedge clk); #1;
      bus.req_write = 2'b00;
      bus.req_addr = {32'd4104, 32'd448};
      bus.req_valid = 2'b11;
      for (int n = 0; n < 4; n++) begin
         acc = 1'b0;
         for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) acc = 1'b1;
         end
         check("fair_accept", acc, 1);
         gid = bus.req_ready[1] ? 1 : 0;
         check("fair_grant", gid, n % 2);
         if (n > 0) check("fair_gap", cyc - last_acc, 4);
         last_acc = cyc;
         sb.push_back('{gid, 1'b1, (gid == 1) ? 8'h3D : 8'h36, cyc + 3});
      end
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      drain();

      // reset during MEM_RD; held request must be re-serviced
      mem_k = 30; mem_line = 64'hAABBCCDDEEFF0011;
      @(posedge clk); #1;
      bus.req_write[0] = 1'b0;
      bus.req_addr[31:0] = 32'd8005;
      bus.req_valid[0] = 1'b1;
      c_resp = n_resp;
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
         @(negedge clk);
         if (bus.mem_req) acc = 1'b1;
      end
      check("midmiss_mem_req_seen", acc, 1);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("midmiss_async_drop", bus.mem_req, 0);
      mem_k = 2;
      repeat (2) @(negedge clk);
      check("midmiss_state", dut.state_q, S_IDLE);
      @(posedge clk); #2;
      reset = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
         @(negedge clk);
         if (bus.req_ready[0]) acc = 1'b1;
      end
      check("midmiss_reaccept", acc, 1);
      check("midmiss_no_resp", n_resp - c_resp, 0);
      sb.push_back('{0, 1'b0, 8'hCC, cyc + 7});
      @(posedge clk); #1;
      bus.req_valid[0] = 1'b0;
      drain();
      check("midmiss_mem_addr", obs_mem_addr, 32'd8000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
